alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_cmd_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, default width and FSM encoding.
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [1:0] OP0 = 2'b00;
   localparam logic [1:0] OP1 = 2'b01;
   localparam logic [1:0] OP2 = 2'b10;
   localparam logic [1:0] OP3 = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Steps one operand pair through the four ALU opcodes, holding each for HOLD cycles,
// and packs the four results into out_data for a valid/ready consumer.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int W    = ALU_W,
   parameter int HOLD = 4
) (
   input  logic           clk,
   input  logic           rst,
   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [1:0]     alu_status,
   input  logic [W-1:0]   alu_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*W-1:0] out_data,
   output logic           busy,
   output state_t         dbg_state
);

   if (HOLD < 2) begin : g_bad_hold
      $error("alu_cmd_sequencer: HOLD must be at least 2");
   end

   localparam int CW = (HOLD < 2) ? 1 : $clog2(HOLD);
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [1:0]     r_status;
   logic [4*W-1:0] r_data;
   logic           r_in_ready;
   logic           r_out_valid;
   logic           r_busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_status    <= OP0;
         r_data      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a        <= in_a;
                  r_b        <= in_b;
                  r_status   <= OP0;
                  r_cnt      <= '0;
                  r_state    <= ST_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               // The ALU has one cycle of latency, so by the last hold cycle its output
               // reflects the current opcode.
               if (r_cnt == LAST) begin
                  r_data[int'(r_status)*W +: W] <= alu_result;
                  if (r_status == OP3) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_status <= r_status + 2'd1;
                     r_cnt    <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_status    <= OP0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_status = r_status;
   assign out_valid  = r_out_valid;
   assign out_data   = r_data;
   assign busy       = r_busy;
   assign dbg_state  = r_state;

endmodule
